uart_rx_param: RTL and testbench



---
 rtl/uart_rx_param.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param -- oversampling UART receiver with parity and stop-bit checks.
//
// Converts the asynchronous serial line into parallel words. Each bit is
// sampled three times around mid-bit and decided by 2-of-3 majority. A start
// bit that does not hold low at mid-bit is treated as a glitch and ignored.
// Words are offered on a valid/ready handshake together with parity and
// framing status. A word that completes while the previous one is still
// unaccepted is dropped and reported with overrun_err.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   TxD         serial line from the remote transmitter (idles high)
//   rx_data     received word, first bit received in bit 0
//   rx_valid    rx_data / parity_err / frame_err are valid
//   rx_ready    consumer accepts the word
//   parity_err  parity mismatch in the held word (0 when PARITY_MODE = 0)
//   frame_err   a stop bit of the held word was sampled low
//   overrun_err one-cycle pulse: a completed frame was dropped
//   busy        receiver is inside a frame
//   break_det   (UART_RX_BREAK_DETECT_EN only) one-cycle pulse when the line
//               returns high after an all-zero frame
//
// Build option: define UART_RX_BREAK_DETECT_EN to enable break detection.
module uart_rx_param #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int DATA_WIDTH      = 8,
  parameter int OVERSAMPLE_RATE = 16,
  parameter int PARITY_MODE     = 1,
  parameter int STOP_BITS       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  TxD,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                  break_det
`endif
);

  localparam int CPT_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE_RATE);
  localparam int CPT     = (CPT_RAW < 1) ? 1 : CPT_RAW;
  localparam int CW      = (CPT > 1) ? $clog2(CPT) : 1;
  localparam int TW      = $clog2(OVERSAMPLE_RATE);
  localparam int H       = OVERSAMPLE_RATE / 2;
  localparam int BW      = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                state_q;
  logic                  sync_q, rxs_q, rxs_prev_q;
  logic [CW-1:0]         cycle_cnt_q;
  logic [TW-1:0]         tick_cnt_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [1:0]            samp_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  pbit_q, ferr_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q, parity_err_q, frame_err_q, overrun_q;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                  zero_q, brk_wait_q, break_q;
  logic                  brk_d;
`endif

  logic tick, wrap, eval_pt, maj, last_stop, load_ok;
  logic par_err_d, frame_err_d;

  always_comb begin
    tick        = (cycle_cnt_q == CW'(CPT - 1));
    wrap        = tick && (tick_cnt_q == TW'(OVERSAMPLE_RATE - 1));
    eval_pt     = tick && (tick_cnt_q == TW'(H + 1));
    // third sample is the live synchronised value at the eval tick
    maj         = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
    last_stop   = (bit_cnt_q == BW'(STOP_BITS - 1));
    load_ok     = !rx_valid_q || rx_ready;
    frame_err_d = ferr_q | ~maj;
    par_err_d   = 1'b0;
    if (PARITY_MODE != 0)
      par_err_d = (^shift_q) ^ pbit_q ^ (PARITY_MODE == 2);
`ifdef UART_RX_BREAK_DETECT_EN
    brk_d       = zero_q & ~maj;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sync_q       <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      cycle_cnt_q  <= '0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      samp_q       <= '1;
      shift_q      <= '0;
      pbit_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      zero_q       <= 1'b0;
      brk_wait_q   <= 1'b0;
      break_q      <= 1'b0;
`endif
    end else begin
      sync_q     <= TxD;
      rxs_q      <= sync_q;
      rxs_prev_q <= rxs_q;
      overrun_q  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      break_q    <= 1'b0;
`endif
      // a completion later in this block overrides this clear
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      if (state_q == S_IDLE) begin
        cycle_cnt_q <= '0;
        tick_cnt_q  <= '0;
      end else if (tick) begin
        cycle_cnt_q <= '0;
        tick_cnt_q  <= wrap ? '0 : tick_cnt_q + 1'b1;
      end else begin
        cycle_cnt_q <= cycle_cnt_q + 1'b1;
      end

      if (tick && (tick_cnt_q == TW'(H - 1))) samp_q[0] <= rxs_q;
      if (tick && (tick_cnt_q == TW'(H)))     samp_q[1] <= rxs_q;

      case (state_q)
        S_IDLE: begin
          if (rxs_prev_q && !rxs_q) begin
            state_q   <= S_START;
            bit_cnt_q <= '0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_q    <= 1'b1;
`endif
          end
        end
        S_START: begin
          if (eval_pt && maj) state_q <= S_IDLE;
          else if (wrap)      state_q <= S_DATA;
        end
        S_DATA: begin
          if (eval_pt) begin
            shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};
`ifdef UART_RX_BREAK_DETECT_EN
            zero_q  <= zero_q & ~maj;
`endif
          end
          if (wrap) begin
            if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (eval_pt) begin
            pbit_q <= maj;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_q <= zero_q & ~maj;
`endif
          end
          if (wrap) state_q <= S_STOP;
        end
        S_STOP: begin
`ifdef UART_RX_BREAK_DETECT_EN
          if (brk_wait_q) begin
            if (rxs_q) begin
              brk_wait_q <= 1'b0;
              break_q    <= 1'b1;
              state_q    <= S_IDLE;
            end
          end else
`endif
          if (eval_pt) begin
            if (!last_stop) begin
              ferr_q    <= frame_err_d;
              bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
              zero_q    <= zero_q & ~maj;
`endif
            end
`ifdef UART_RX_BREAK_DETECT_EN
            else if (brk_d) begin
              brk_wait_q <= 1'b1;
            end
`endif
            else begin
              // leave half a bit early so a back-to-back start edge is seen
              state_q <= S_IDLE;
              if (load_ok) begin
                rx_data_q    <= shift_q;
                parity_err_q <= par_err_d;
                frame_err_q  <= frame_err_d;
                rx_valid_q   <= 1'b1;
              end else begin
                overrun_q    <= 1'b1;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign busy        = (state_q != S_IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
  assign break_det   = break_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: instance 0 is even parity / 1 stop bit, instance 1
// is odd parity / 2 stop bits, both 8 data bits at 16 clocks per bit.
module tb_uart_rx_param;
  localparam int NDUT = 2;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic txd[NDUT];
  logic ready[NDUT];
  logic [7:0] rdata[NDUT];
  logic rvalid[NDUT], perr[NDUT], ferr[NDUT], ovr[NDUT], busy[NDUT];
`ifdef UART_RX_BREAK_DETECT_EN
  logic brk[NDUT];
`endif

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_rx_param #(
      .CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_WIDTH(8),
      .OVERSAMPLE_RATE(16), .PARITY_MODE(g == 0 ? 1 : 2), .STOP_BITS(g == 0 ? 1 : 2)
    ) u_dut (
      .clk(clk), .reset(reset), .TxD(txd[g]),
      .rx_data(rdata[g]), .rx_valid(rvalid[g]), .rx_ready(ready[g]),
      .parity_err(perr[g]), .frame_err(ferr[g]), .overrun_err(ovr[g]), .busy(busy[g])
`ifdef UART_RX_BREAK_DETECT_EN
      , .break_det(brk[g])
`endif
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference rules: count ones of data plus parity bit.
  function automatic logic exp_perr(input int d, input logic [7:0] data, input logic pbit);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(data[i]);
    ones += int'(pbit);
    if (d == 0) return (ones % 2) != 0;
    return (ones % 2) == 0;
  endfunction

  exp_t        sb[NDUT][$];
  int unsigned start_cyc = 0;
  int unsigned rise_cyc[NDUT] = '{0, 0};
  int          rise_cnt[NDUT] = '{0, 0};
  int          ovr_cnt[NDUT]  = '{0, 0};
  int          exp_ovr[NDUT]  = '{0, 0};
  int          busy_cnt[NDUT] = '{0, 0};
  int          brk_cnt[NDUT]  = '{0, 0};
  logic        hold[NDUT]     = '{0, 0};
  logic        prev_v[NDUT]   = '{0, 0};
  logic [7:0]  hold_data[NDUT];
  logic        hold_p[NDUT], hold_f[NDUT];
  logic [7:0]  last_data[NDUT] = '{0, 0};
  logic        last_p[NDUT]    = '{0, 0};
  logic        last_f[NDUT]    = '{0, 0};

  // Compare process: every accepted word against the scoreboard, held words
  // for stability, plus event counters.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      if (reset) begin
        hold[d]   = 1'b0;
        prev_v[d] = 1'b0;
      end else begin
        if (hold[d]) begin
          chk($sformatf("dut%0d held valid", d), rvalid[d], 1);
          chk($sformatf("dut%0d held data", d), rdata[d], hold_data[d]);
          chk($sformatf("dut%0d held perr", d), perr[d], hold_p[d]);
          chk($sformatf("dut%0d held ferr", d), ferr[d], hold_f[d]);
        end
        if (rvalid[d] && !prev_v[d]) begin
          rise_cnt[d]++;
          rise_cyc[d] = cyc;
        end
        if (rvalid[d] && ready[d]) begin
          if (sb[d].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d unexpected word: got data %0h, expected no word", d, rdata[d]);
          end else begin
            e = sb[d].pop_front();
            chk($sformatf("dut%0d data", d), rdata[d], e.data);
            chk($sformatf("dut%0d parity_err", d), perr[d], e.perr);
            chk($sformatf("dut%0d frame_err", d), ferr[d], e.ferr);
            last_data[d] = rdata[d];
            last_p[d]    = perr[d];
            last_f[d]    = ferr[d];
          end
        end
        hold[d] = rvalid[d] && !ready[d];
        hold_data[d] = rdata[d];
        hold_p[d]    = perr[d];
        hold_f[d]    = ferr[d];
        if (ovr[d])  ovr_cnt[d]++;
        if (busy[d]) busy_cnt[d]++;
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk[d])  brk_cnt[d]++;
`endif
        prev_v[d] = rvalid[d];
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame, 16 clocks per bit. glitch_slot inverts one clock in
  // the middle of that bit slot (-1 = none).
  task automatic send(input int d, input logic [7:0] data, input logic pbit,
                      input logic [1:0] stops, input int glitch_slot, input bit push);
    int         nst;
    int         nbits;
    logic [11:0] frame;
    exp_t       e;
    nst   = (d == 0) ? 1 : 2;
    nbits = 10 + nst;
    frame = '1;
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[1 + i] = data[i];
    frame[9] = pbit;
    for (int k = 0; k < nst; k++) frame[10 + k] = stops[k];
    if (push) begin
      e.data = data;
      e.perr = exp_perr(d, data, pbit);
      e.ferr = (nst == 1) ? !stops[0] : !(stops[0] && stops[1]);
      sb[d].push_back(e);
    end
    start_cyc = cyc;
    for (int s = 0; s < nbits; s++) begin
      for (int j = 0; j < 16; j++) begin
        txd[d] = (s == glitch_slot && j == 10) ? ~frame[s] : frame[s];
        @(posedge clk);
        #1;
      end
    end
    txd[d] = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    logic [7:0] data;
    logic       pbit;
    logic [1:0] stops;
    int         gl;
    for (int d = 0; d < NDUT; d++) begin
      txd[d]   = 1'b1;
      ready[d] = 1'b1;
    end
    idle(4);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("dut%0d reset rx_data", d), rdata[d], 0);
      chk($sformatf("dut%0d reset rx_valid", d), rvalid[d], 0);
      chk($sformatf("dut%0d reset parity_err", d), perr[d], 0);
      chk($sformatf("dut%0d reset frame_err", d), ferr[d], 0);
      chk($sformatf("dut%0d reset overrun_err", d), ovr[d], 0);
      chk($sformatf("dut%0d reset busy", d), busy[d], 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(5);

    // 1: clean even-parity frame; latency pinned by hand
    send(0, 8'hA5, 1'b0, 2'b11, -1, 1);
    idle(20);
    chk("t1 latency", rise_cyc[0] - start_cyc, 173);
    chk("t1 data", last_data[0], 8'hA5);
    chk("t1 parity_err", last_p[0], 0);
    chk("t1 frame_err", last_f[0], 0);
    chk("t1 valid pulses", rise_cnt[0], 1);

    // 2: flipped parity bit, then odd-mode instance with correct parity
    send(0, 8'hA5, 1'b1, 2'b11, -1, 1);
    idle(20);
    chk("t2 data", last_data[0], 8'hA5);
    chk("t2 parity_err", last_p[0], 1);
    send(1, 8'hA5, 1'b1, 2'b11, -1, 1);
    idle(20);
    chk("t2 odd latency", rise_cyc[1] - start_cyc, 189);
    chk("t2 odd parity_err", last_p[1], 0);

    // 3: short low glitch while idle
    r0 = rise_cnt[0];
    busy_cnt[0] = 0;
    txd[0] = 1'b0;
    idle(4);
    txd[0] = 1'b1;
    idle(30);
    chk("t3 busy cycles in 1..12", (busy_cnt[0] >= 1) && (busy_cnt[0] <= 12), 1);
    chk("t3 no word", rise_cnt[0], r0);
    chk("t3 busy low after", busy[0], 0);

    // 4: overrun with consumer stalled
    ready[0] = 1'b0;
    send(0, 8'h11, 1'b0, 2'b11, -1, 1);
    send(0, 8'h22, 1'b0, 2'b11, -1, 0);
    exp_ovr[0]++;
    idle(5);
    chk("t4 overrun count", ovr_cnt[0], exp_ovr[0]);
    chk("t4 held data", rdata[0], 8'h11);
    chk("t4 held valid", rvalid[0], 1);
    ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4 valid drops", rvalid[0], 0);
    @(posedge clk);
    #1;

    // 5: second stop bit low; single-clock glitch inside data bit 2
    send(1, 8'h5A, 1'b1, 2'b01, -1, 1);
    idle(6);
    chk("t5 frame_err", last_f[1], 1);
    chk("t5 data", last_data[1], 8'h5A);
    send(1, 8'hA5, 1'b1, 2'b11, 3, 1);
    idle(20);
    chk("t5 glitch data", last_data[1], 8'hA5);
    chk("t5 glitch frame_err", last_f[1], 0);

    // 6: reset during data bit 4, then a clean frame
    txd[0] = 1'b0;
    idle(16);
    for (int i = 0; i < 4; i++) begin
      txd[0] = i[0];
      idle(16);
    end
    txd[0] = 1'b1;
    idle(8);
    reset = 1'b1;
    idle(2);
    @(negedge clk);
    chk("t6 reset valid", rvalid[0], 0);
    chk("t6 reset busy", busy[0], 0);
    chk("t6 reset data", rdata[0], 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(5);
    r0 = rise_cnt[0];
    send(0, 8'h3C, 1'b0, 2'b11, -1, 1);
    idle(20);
    chk("t6 data", last_data[0], 8'h3C);
    chk("t6 one word", rise_cnt[0], r0 + 1);

`ifdef UART_RX_BREAK_DETECT_EN
    r0 = rise_cnt[0];
    brk_cnt[0] = 0;
    txd[0] = 1'b0;
    idle(30 * 16);
    txd[0] = 1'b1;
    idle(40);
    chk("break pulses", brk_cnt[0], 1);
    chk("break no word", rise_cnt[0], r0);
`else
    send(0, 8'h00, 1'b0, 2'b00, -1, 1);
    txd[0] = 1'b1;
    idle(10);
    chk("zero frame data", last_data[0], 0);
    chk("zero frame frame_err", last_f[0], 1);
`endif
    idle(10);

    // randomized frames, both instances, with back-to-back and glitches
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 25; n++) begin
        data  = 8'($urandom);
        pbit  = 1'($urandom);
        stops = 2'b11;
        if ($urandom_range(0, 5) == 0) stops[$urandom_range(0, d)] = 1'b0;
        if (data == 8'h00) data = 8'h80;
        gl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10 + d)) : -1;
        send(d, data, pbit, stops, gl, 1);
        if ((d == 0 && !stops[0]) || (d == 1 && !stops[1])) idle(int'($urandom_range(4, 20)));
        else idle(int'($urandom_range(0, 20)));
      end
      idle(30);
    end

    idle(50);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("dut%0d words left undelivered", d), sb[d].size(), 0);
      chk($sformatf("dut%0d final overrun count", d), ovr_cnt[d], exp_ovr[d]);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
